// File: rtl/encrypt_pkg.sv
// ============================================================================
// Module  : encrypt_pkg
// Purpose : Shared constants, FSM state type and helper function for the
//           Encrypt core scheduler.
// Contents: c_BLOCK_SIZE / c_KEY_SIZE  - Encrypt core block and key sizes
//           c_DATA_W / c_KEY_W         - datapath widths tied to the above
//           state_t                    - scheduler FSM encoding
//           id_width()                 - width of a requester index
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package encrypt_pkg;

    localparam int c_BLOCK_SIZE = 64;
    localparam int c_KEY_SIZE   = 128;

    localparam int c_DATA_W     = c_BLOCK_SIZE;
    localparam int c_KEY_W      = c_KEY_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    // Never returns 0, so a single-requester build still gets a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/encrypt_scheduler_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. Picks the first asserted
//           request searching upward from last_grant+1, wrapping modulo
//           NUM_REQ. The priority pointer is held by the instantiating block.
// Ports   : i_req        - request vector
//           i_last_grant - index of the previous winner
//           o_grant      - one-hot grant (all zero when no request)
//           o_grant_idx  - binary index of the winner
//           o_any_valid  - at least one request is pending
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import encrypt_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_valid
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Offsets run 1..NUM_REQ so the previous winner is visited last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_valid = |i_req;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/encrypt_scheduler.sv
// ============================================================================
// Module  : encrypt_scheduler
// Purpose : Shares one Encrypt core among NUM_REQ requesters. Round-robin
//           arbitration, job sequencing (restart, enable, wait for Done with
//           timeout) and a valid/ready response tagged with the requester ID.
// Ports   : clk, rst                        - clock, async active-high reset
//           req_valid/req_ready             - per-requester request handshake
//           req_plaintext/req_key           - packed per-requester data
//           rsp_valid/rsp_ready             - response handshake
//           rsp_id/rsp_ciphertext/rsp_error - response payload
//           core_*                          - Encrypt core interface
//           busy                            - scheduler not idle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module encrypt_scheduler
    import encrypt_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = c_DATA_W,
    parameter  int KEY_W       = c_KEY_W,
    parameter  int TIMEOUT_CYC = 1023,
    localparam int ID_W        = id_width(NUM_REQ),
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_plaintext,
    input  logic [NUM_REQ*KEY_W-1:0]  req_key,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_ciphertext,
    output logic                      rsp_error,
    output logic [DATA_W-1:0]         core_plaintext,
    output logic [KEY_W-1:0]          core_key,
    output logic                      core_restart,
    output logic                      core_enable,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_ciphertext,
    output logic                      busy
);

    state_t              r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_ct;
    logic                r_rsp_error;
    logic [DATA_W-1:0]   r_core_pt;
    logic [KEY_W-1:0]    r_core_key;
    logic                r_core_restart;
    logic                r_core_enable;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any_valid;

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_valid  (w_any_valid)
    );

    // The accept pulse must coincide with the arbitration cycle, so it is
    // decoded from state rather than registered; reset masks it so every
    // output reads 0 while rst is held.
    assign req_ready      = (r_state == IDLE && !rst) ? w_grant : '0;

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_ciphertext = r_rsp_ct;
    assign rsp_error      = r_rsp_error;
    assign core_plaintext = r_core_pt;
    assign core_key       = r_core_key;
    assign core_restart   = r_core_restart;
    assign core_enable    = r_core_enable;
    assign busy           = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_id           <= '0;
            r_cnt          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_ct       <= '0;
            r_rsp_error    <= 1'b0;
            r_core_pt      <= '0;
            r_core_key     <= '0;
            r_core_restart <= 1'b0;
            r_core_enable  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_state        <= LOAD;
                        r_busy         <= 1'b1;
                        r_core_restart <= 1'b1;
                        r_core_pt      <= req_plaintext[w_grant_idx*DATA_W +: DATA_W];
                        r_core_key     <= req_key[w_grant_idx*KEY_W +: KEY_W];
                        r_id           <= w_grant_idx;
                        r_last_grant   <= w_grant_idx;
                    end
                end
                LOAD: begin
                    r_state        <= BUSY;
                    r_core_restart <= 1'b0;
                    r_core_enable  <= 1'b1;
                    r_cnt          <= '0;
                end
                BUSY: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (core_done) begin
                        r_state       <= RESP;
                        r_core_enable <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_id      <= r_id;
                        r_rsp_ct      <= core_ciphertext;
                        r_rsp_error   <= 1'b0;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state       <= RESP;
                        r_core_enable <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_id      <= r_id;
                        r_rsp_ct      <= '0;
                        r_rsp_error   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b0;
                        r_rsp_id    <= '0;
                        r_rsp_ct    <= '0;
                        r_rsp_error <= 1'b0;
                        r_core_pt   <= '0;
                        r_core_key  <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_encrypt_scheduler.sv
// ============================================================================
// Module  : tb_encrypt_scheduler
// Purpose : Self-checking bench for encrypt_scheduler with a behavioural
//           Encrypt core whose Done latency is set per job.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encrypt_scheduler;

    localparam int c_N   = 4;
    localparam int c_DW  = 64;
    localparam int c_KW  = 128;
    localparam int c_TO  = 24;

    logic                  clk;
    logic                  rst;
    logic [c_N-1:0]        req_valid;
    logic [c_N-1:0]        req_ready;
    logic [c_N*c_DW-1:0]   req_plaintext;
    logic [c_N*c_KW-1:0]   req_key;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [c_DW-1:0]       rsp_ciphertext;
    logic                  rsp_error;
    logic [c_DW-1:0]       core_plaintext;
    logic [c_KW-1:0]       core_key;
    logic                  core_restart;
    logic                  core_enable;
    logic                  core_done;
    logic [c_DW-1:0]       core_ciphertext;
    logic                  busy;

    encrypt_scheduler #(
        .NUM_REQ     (c_N),
        .DATA_W      (c_DW),
        .KEY_W       (c_KW),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_plaintext   (req_plaintext),
        .req_key         (req_key),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_ciphertext  (rsp_ciphertext),
        .rsp_error       (rsp_error),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_restart    (core_restart),
        .core_enable     (core_enable),
        .core_done       (core_done),
        .core_ciphertext (core_ciphertext),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural Encrypt core ----------------
    // done_lat = N asserts Done on the Nth enabled cycle; 0 means never.
    int unsigned done_lat;
    logic        force_done;
    int unsigned en_cnt;

    initial en_cnt = 0;
    always @(posedge clk) begin
        if (core_restart)     en_cnt <= 0;
        else if (core_enable) en_cnt <= en_cnt + 1;
    end

    assign core_done       = force_done |
                             (core_enable && (done_lat != 0) && (en_cnt == done_lat - 1));
    assign core_ciphertext = core_plaintext ^ core_key[127:64] ^ core_key[63:0];

    // ---------------- stimulus data ----------------
    logic [c_DW-1:0] pt  [c_N];
    logic [c_KW-1:0] key [c_N];

    function automatic logic [c_DW-1:0] golden(input int i);
        logic [c_KW-1:0] k;
        k = key[i];
        return pt[i] ^ k[127:64] ^ k[63:0];
    endfunction

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] rv;
        int         lat;
        int         id;
        logic       err;
        int         en;
    } vec_t;

    vec_t vecs [11];

    // One complete job with rsp_ready held high.
    task automatic run_job(input vec_t v);
        int   k;
        logic bad;
        rsp_ready = 1'b1;
        done_lat  = v.lat;
        req_valid = v.rv;
        #1;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("grant", 128'(req_ready), 128'(1) << v.id);
        @(negedge clk);
        check("restart",  128'(core_restart), 128'(1));
        check("core_pt",  128'(core_plaintext), 128'(pt[v.id]));
        check("core_key", core_key, key[v.id]);
        bad = 1'b0;
        k   = 0;
        while (!rsp_valid && k < 200) begin
            if (req_ready != '0 || !busy) bad = 1'b1;
            @(negedge clk);
            k++;
        end
        check("busy_noready", 128'(bad), 128'(0));
        check("rsp_valid", 128'(rsp_valid), 128'(1));
        check("rsp_id",    128'(rsp_id), 128'(v.id));
        check("rsp_err",   128'(rsp_error), 128'(v.err));
        check("rsp_ct",    128'(rsp_ciphertext), v.err ? 128'(0) : 128'(golden(v.id)));
        check("en_cycles", 128'(en_cnt), 128'(v.en));
        req_valid = '0;
        @(negedge clk);
        check("rsp_drop", 128'(rsp_valid), 128'(0));
        check("idle",     128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        logic bad;
        vec_t v;

        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        done_lat   = 0;
        force_done = 1'b0;

        pt[0]  = 64'hDEADBEEF00000001;
        pt[1]  = 64'h1122334455667788;
        pt[2]  = 64'h0123456789ABCDEF;
        pt[3]  = 64'hA5A5A5A5_5A5A5A5A;
        key[0] = 128'h000102030405060708090A0B0C0D0E0F;
        key[1] = 128'hFFEEDDCCBBAA99887766554433221100;
        key[2] = 128'h0F1571C947D9E8590CB7ADD6AF7F6798;
        key[3] = 128'h13579BDF2468ACE0FEDCBA9876543210;
        for (int i = 0; i < c_N; i++) begin
            req_plaintext[i*c_DW +: c_DW] = pt[i];
            req_key[i*c_KW +: c_KW]       = key[i];
        end

        //            rv       lat id err en
        vecs[0]  = '{4'b0100, 20, 2, 1'b0, 20};
        vecs[1]  = '{4'b1111,  3, 3, 1'b0,  3};
        vecs[2]  = '{4'b1111,  3, 0, 1'b0,  3};
        vecs[3]  = '{4'b1111,  3, 1, 1'b0,  3};
        vecs[4]  = '{4'b1111,  3, 2, 1'b0,  3};
        vecs[5]  = '{4'b1111,  3, 3, 1'b0,  3};
        vecs[6]  = '{4'b1111,  3, 0, 1'b0,  3};
        vecs[7]  = '{4'b0011,  0, 1, 1'b1, 24};
        vecs[8]  = '{4'b0011, 24, 0, 1'b0, 24};
        vecs[9]  = '{4'b1000,  1, 3, 1'b0,  1};
        vecs[10] = '{4'b0110,  7, 1, 1'b0,  7};

        // Asynchronous reset in the middle of a clock phase.
        #3 rst = 1'b1;
        #1;
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_enable",    128'(core_enable), 128'(0));
        check("rst_restart",   128'(core_restart), 128'(0));
        check("rst_ready",     128'(req_ready), 128'(0));
        check("rst_busy",      128'(busy), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 11; i++) run_job(vecs[i]);

        // Response back-pressure: payload held, no new accept while pending.
        rsp_ready = 1'b0;
        done_lat  = 5;
        req_valid = 4'b0011;
        #1;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_grant", 128'(req_ready), 128'(4'b0001));
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid", 128'(rsp_valid), 128'(1));
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_id != 2'd0 || rsp_ciphertext != golden(0) ||
                req_ready != '0 || !busy)
                bad = 1'b1;
        end
        check("bp_hold", 128'(bad), 128'(0));
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("bp_done_valid", 128'(rsp_valid), 128'(0));
        check("bp_done_busy",  128'(busy), 128'(0));

        // Done outside BUSY must not start or complete anything.
        force_done = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_done_valid", 128'(rsp_valid), 128'(0));
        check("stray_done_busy",  128'(busy), 128'(0));
        force_done = 1'b0;

        // Reset during BUSY of requester 3 discards the job.
        done_lat  = 0;
        req_valid = 4'b1000;
        #1;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_grant", 128'(req_ready), 128'(4'b1000));
        k = 0;
        while (!core_enable && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_enable", 128'(core_enable), 128'(1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_enable", 128'(core_enable), 128'(0));
        check("mid_rst_valid",  128'(rsp_valid), 128'(0));
        check("mid_rst_busy",   128'(busy), 128'(0));
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_valid", 128'(rsp_valid), 128'(0));
        v = '{4'b1001, 2, 0, 1'b0, 2};
        run_job(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
